// File: rtl/gamma_lut_banked.sv
// rtl/gamma_lut_banked.sv - per-channel double-banked gamma LUT with VSync-aligned bank swap
module gamma_lut_banked #(
  parameter int CW  = 8,
  parameter int OW  = 8,
  parameter int NCH = 3
) (
  input  logic                                  clk_vid,
  input  logic                                  reset,
  input  logic                                  ce_pix,
  input  logic                                  gamma_en,
  input  logic                                  HSync,
  input  logic                                  VSync,
  input  logic                                  HBlank,
  input  logic                                  VBlank,
  input  logic                                  DE,
  input  logic [NCH*CW-1:0]                     RGB_in,
  output logic                                  HSync_out,
  output logic                                  VSync_out,
  output logic                                  HBlank_out,
  output logic                                  VBlank_out,
  output logic                                  DE_out,
  output logic [NCH*OW-1:0]                     RGB_out,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_chan,
  input  logic [CW-1:0]                         wr_addr,
  input  logic [OW-1:0]                         wr_data,
  input  logic                                  commit,
  output logic                                  swap_pending,
  output logic                                  active_bank
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  swap_state_t state, state_nxt;
  logic        swap;
  logic        vs_prev;

  logic [NCH*CW-1:0] s1_rgb;
  logic              s1_hs, s1_vs, s1_hb, s1_vb, s1_de;

  logic [OW-1:0] lut [NCH][2][2**CW];

  // Output bit i (from MSB) takes input bit (i mod CW) from MSB: identity,
  // MSB replication when widening, truncation to the top bits when narrowing.
  function automatic logic [OW-1:0] bypass(input logic [CW-1:0] x);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < OW; i++) begin
      r[OW-1-i] = x[CW-1-(i % CW)];
    end
    return r;
  endfunction

  assign swap_pending = (state == PENDING);
  assign wr_ready     = (state == IDLE);

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      IDLE: begin
        if (commit) state_nxt = PENDING;
      end
      PENDING: begin
        if (ce_pix && VSync && !vs_prev) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state       <= IDLE;
      active_bank <= 1'b0;
      vs_prev     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (swap) active_bank <= ~active_bank;
      if (ce_pix) vs_prev <= VSync;
    end
  end

  // Host writes only ever target the shadow bank, so they never collide with the S2 read.
  always_ff @(posedge clk_vid) begin
    if (!reset && wr_valid && wr_ready && (int'(wr_chan) < NCH)) begin
      lut[wr_chan][~active_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      s1_rgb     <= '0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_hb      <= 1'b0;
      s1_vb      <= 1'b0;
      s1_de      <= 1'b0;
      RGB_out    <= '0;
      HSync_out  <= 1'b0;
      VSync_out  <= 1'b0;
      HBlank_out <= 1'b0;
      VBlank_out <= 1'b0;
      DE_out     <= 1'b0;
    end else if (ce_pix) begin
      s1_rgb     <= RGB_in;
      s1_hs      <= HSync;
      s1_vs      <= VSync;
      s1_hb      <= HBlank;
      s1_vb      <= VBlank;
      s1_de      <= DE;
      HSync_out  <= s1_hs;
      VSync_out  <= s1_vs;
      HBlank_out <= s1_hb;
      VBlank_out <= s1_vb;
      DE_out     <= s1_de;
      // active_bank here is the pre-swap value even in the swap cycle.
      for (int c = 0; c < NCH; c++) begin
        RGB_out[(NCH-1-c)*OW +: OW] <= gamma_en
          ? lut[c][active_bank][s1_rgb[(NCH-1-c)*CW +: CW]]
          : bypass(s1_rgb[(NCH-1-c)*CW +: CW]);
      end
    end
  end

endmodule

// File: tb/tb_gamma_lut_banked.sv
// tb/tb_gamma_lut_banked.sv - directed bench for gamma_lut_banked (8->8 and 8->10 instances)
module tb_gamma_lut_banked;

  logic        clk_vid = 1'b0;
  logic        reset, ce_pix, gamma_en;
  logic        HSync, VSync, HBlank, VBlank, DE;
  logic [23:0] RGB_in;
  logic        HSync_out, VSync_out, HBlank_out, VBlank_out, DE_out;
  logic [23:0] RGB_out;
  logic        wr_valid, wr_ready;
  logic [1:0]  wr_chan;
  logic [7:0]  wr_addr, wr_data;
  logic        commit, swap_pending, active_bank;

  logic        hs10, vs10, hb10, vb10, de10, wr_ready10, pend10, bank10;
  logic [29:0] rgb10;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_vid = ~clk_vid;

  gamma_lut_banked #(.CW(8), .OW(8), .NCH(3)) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .gamma_en(gamma_en),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank), .DE(DE),
    .RGB_in(RGB_in),
    .HSync_out(HSync_out), .VSync_out(VSync_out), .HBlank_out(HBlank_out),
    .VBlank_out(VBlank_out), .DE_out(DE_out), .RGB_out(RGB_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .swap_pending(swap_pending), .active_bank(active_bank)
  );

  gamma_lut_banked #(.CW(8), .OW(10), .NCH(3)) dut10 (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .gamma_en(gamma_en),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank), .DE(DE),
    .RGB_in(RGB_in),
    .HSync_out(hs10), .VSync_out(vs10), .HBlank_out(hb10),
    .VBlank_out(vb10), .DE_out(de10), .RGB_out(rgb10),
    .wr_valid(wr_valid), .wr_ready(wr_ready10), .wr_chan(wr_chan),
    .wr_addr(wr_addr), .wr_data({2'b00, wr_data}),
    .commit(commit), .swap_pending(pend10), .active_bank(bank10)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vid);
    #1;
  endtask

  task automatic lut_wr(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_chan  = ch;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b1; gamma_en = 1'b0;
    HSync = 1'b0; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0; DE = 1'b0;
    RGB_in = '0; wr_valid = 1'b0; wr_chan = '0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    tick(); tick();

    check_eq("rst_rgb", RGB_out, 24'h0);
    check_eq("rst_wr_ready", wr_ready, 1'b1);
    check_eq("rst_pending", swap_pending, 1'b0);
    check_eq("rst_bank", active_bank, 1'b0);
    check_eq("rst_hs", HSync_out, 1'b0);
    check_eq("rst_rgb10", rgb10, 30'h0);
    reset = 1'b0;

    // 1: bypass latency with syncs
    RGB_in = 24'h123456; HSync = 1'b1; VBlank = 1'b1; DE = 1'b1;
    tick();
    check_eq("t1_not_yet", RGB_out, 24'h0);
    RGB_in = 24'h0; HSync = 1'b0; VBlank = 1'b0; DE = 1'b0;
    tick();
    check_eq("t1_rgb", RGB_out, 24'h123456);
    check_eq("t1_hs", HSync_out, 1'b1);
    check_eq("t1_vb", VBlank_out, 1'b1);
    check_eq("t1_de", DE_out, 1'b1);
    tick();
    check_eq("t1_next", RGB_out, 24'h0);

    // 2: load inverse curve in shadow bank 1, swap on VSync rise
    for (int x = 0; x < 256; x++) lut_wr(2'd0, 8'(x), 8'(255 - x));
    lut_wr(2'd1, 8'h20, 8'h77);
    lut_wr(2'd2, 8'h30, 8'h99);
    lut_wr(2'd3, 8'h10, 8'h55);
    commit = 1'b1; tick(); commit = 1'b0;
    check_eq("t2_pending", swap_pending, 1'b1);
    check_eq("t2_wr_ready", wr_ready, 1'b0);
    tick();
    check_eq("t2_bank_wait", active_bank, 1'b0);
    VSync = 1'b1; tick();
    check_eq("t2_bank_swap", active_bank, 1'b1);
    check_eq("t2_pending_clr", swap_pending, 1'b0);
    gamma_en = 1'b1; RGB_in = 24'h102030;
    tick(); tick();
    check_eq("t2_lut", RGB_out, 24'hEF7799);

    // 3: commit with VSync already high; stalled write survives
    commit = 1'b1; tick(); commit = 1'b0;
    wr_valid = 1'b1; wr_chan = 2'd0; wr_addr = 8'h10; wr_data = 8'h42;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_wr_stall", wr_ready, 1'b0);
      check_eq("t3_no_swap", active_bank, 1'b1);
    end
    VSync = 1'b0; tick();
    check_eq("t3_still_pend", swap_pending, 1'b1);
    VSync = 1'b1; tick();
    check_eq("t3_swap", active_bank, 1'b0);
    check_eq("t3_wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;

    // 4: write and commit in the same cycle; second commit ignored
    wr_valid = 1'b1; wr_chan = 2'd0; wr_addr = 8'h20; wr_data = 8'h5A; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    check_eq("t4_pending", swap_pending, 1'b1);
    VSync = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
    VSync = 1'b1; tick();
    check_eq("t4_swap", active_bank, 1'b1);
    check_eq("t4_pending_clr", swap_pending, 1'b0);
    VSync = 1'b0; tick(); VSync = 1'b1; tick();
    check_eq("t4_no_second_swap", active_bank, 1'b1);
    RGB_in = 24'h102030; tick();
    RGB_in = 24'h202030; tick();
    check_eq("t4_stalled_wr", RGB_out, 24'h427799);
    RGB_in = 24'h112030; tick();
    check_eq("t4_same_cycle_wr", RGB_out, 24'h5A7799);
    RGB_in = 24'h203040; tick();
    check_eq("t4_curve_kept", RGB_out, 24'hEE7799);
    gamma_en = 1'b0; tick();
    check_eq("t4_gamma_off", RGB_out, 24'h203040);

    // 5: reset while a swap is pending
    VSync = 1'b0; tick();
    commit = 1'b1; tick(); commit = 1'b0;
    check_eq("t5_pending", swap_pending, 1'b1);
    reset = 1'b1; tick();
    check_eq("t5_pend_rst", swap_pending, 1'b0);
    check_eq("t5_bank_rst", active_bank, 1'b0);
    check_eq("t5_wr_ready", wr_ready, 1'b1);
    check_eq("t5_rgb_rst", RGB_out, 24'h0);
    reset = 1'b0; tick();
    VSync = 1'b1; tick();
    check_eq("t5_no_swap", active_bank, 1'b0);
    check_eq("t5_no_pend", swap_pending, 1'b0);

    // 6: 8->10 bypass widening and ce_pix hold
    gamma_en = 1'b0; RGB_in = 24'hFF8000;
    tick(); tick();
    check_eq("t6_widen", rgb10, 30'h3FF80800);
    check_eq("t6_narrow_pass", RGB_out, 24'hFF8000);
    ce_pix = 1'b0; RGB_in = 24'h010203; HSync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t6_hold10", rgb10, 30'h3FF80800);
      check_eq("t6_hold8", RGB_out, 24'hFF8000);
      check_eq("t6_hold_hs", HSync_out, 1'b0);
    end
    ce_pix = 1'b1; tick(); tick();
    check_eq("t6_resume10", rgb10, 30'h0040200C);
    check_eq("t6_resume_hs", HSync_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
